// File: rtl/mp_alu_seq_pkg.sv
// Shared definitions for the multi-precision ALU sequencer and its parent:
// ALU op-codes, the sequencer state encoding and the word-width helper.
package mp_alu_seq_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_ADC  = 3'd1;
    localparam logic [2:0] ALU_SBB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;
    localparam logic [2:0] ALU_NOT  = 3'd6;
    localparam logic [2:0] ALU_ZERO = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full operand width for a given byte count.
    function automatic int word_w(input int nbytes);
        return 8 * nbytes;
    endfunction

endpackage

// File: rtl/mp_alu_seq_if.sv
// Bundle of the request/result signals and the byte-wide ALU connection.
// master: the parent (issues requests, hosts the ALU); slave: the sequencer.
interface mp_alu_seq_if #(
    parameter int NBYTES = 4
);
    import mp_alu_seq_pkg::*;

    localparam int W = word_w(NBYTES);

    logic         start;
    logic [2:0]   op_in;
    logic         ci_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] res_out;
    logic         co_out;
    logic         z_out;
    logic [2:0]   alu_op;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_ci;
    logic [7:0]   alu_result;
    logic         alu_co;

    modport master (
        output start, op_in, ci_in, a_in, b_in,
        input  busy, done, res_out, co_out, z_out,
        input  alu_op, alu_a, alu_b, alu_ci,
        output alu_result, alu_co
    );

    modport slave (
        input  start, op_in, ci_in, a_in, b_in,
        output busy, done, res_out, co_out, z_out,
        output alu_op, alu_a, alu_b, alu_ci,
        input  alu_result, alu_co
    );

endinterface

// File: rtl/mp_alu_seq.sv
// Multi-precision sequencer: runs one NBYTES-wide operation through an
// external 8-bit ALU, one byte per cycle LSB first, chaining carry/borrow,
// and publishes the full result with carry and zero flags in one DONE cycle.
module mp_alu_seq
    import mp_alu_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mp_alu_seq_if.slave    bus
);

    localparam int W  = word_w(NBYTES);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t         state_reg, state_next;
    logic [IW-1:0]  idx_reg;
    logic           carry_reg;
    logic [2:0]     op_reg;
    logic [W-1:0]   a_reg, b_reg;
    logic [W-1:0]   shadow_reg;
    logic [W-1:0]   res_reg;
    logic           co_reg;
    logic           z_reg;

    logic [7:0]     a_bytes [NBYTES];
    logic [7:0]     b_bytes [NBYTES];
    logic [W-1:0]   captured;
    logic           arith;

    // Ops whose ALU carry-out is meaningful and must be chained.
    assign arith = (op_reg == ALU_ADD) || (op_reg == ALU_ADC) || (op_reg == ALU_SBB);

    // Byte views of the latched operands, and the shadow word with the
    // current ALU byte merged in at the active index.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
        assign a_bytes[gi] = a_reg[gi*8 +: 8];
        assign b_bytes[gi] = b_reg[gi*8 +: 8];
        assign captured[gi*8 +: 8] = (idx_reg == IW'(gi)) ? bus.alu_result
                                                          : shadow_reg[gi*8 +: 8];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and ALU drive; ALU is parked on ZERO outside RUN.
    always_comb begin
        state_next = state_reg;
        bus.alu_op = ALU_ZERO;
        bus.alu_a  = 8'h00;
        bus.alu_b  = 8'h00;
        bus.alu_ci = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.alu_a = a_bytes[idx_reg];
                bus.alu_b = b_bytes[idx_reg];
                if (op_reg == ALU_ADD) begin
                    // Plain add on byte 0, then add-with-carry up the word.
                    bus.alu_op = (idx_reg == '0) ? ALU_ADD : ALU_ADC;
                    bus.alu_ci = (idx_reg == '0) ? 1'b0 : carry_reg;
                end else begin
                    bus.alu_op = op_reg;
                    bus.alu_ci = ((op_reg == ALU_ADC) || (op_reg == ALU_SBB)) ? carry_reg : 1'b0;
                end
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = (state_reg == DONE);
    assign bus.res_out = res_reg;
    assign bus.co_out  = co_reg;
    assign bus.z_out   = z_reg;

    // Operand latch, byte capture, carry chain and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg    <= '0;
            carry_reg  <= 1'b0;
            op_reg     <= ALU_ADD;
            a_reg      <= '0;
            b_reg      <= '0;
            shadow_reg <= '0;
            res_reg    <= '0;
            co_reg     <= 1'b0;
            z_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a_in;
                        b_reg     <= bus.b_in;
                        op_reg    <= bus.op_in;
                        idx_reg   <= '0;
                        carry_reg <= ((bus.op_in == ALU_ADC) || (bus.op_in == ALU_SBB)) ? bus.ci_in : 1'b0;
                    end
                end
                RUN: begin
                    shadow_reg <= captured;
                    // Logical ops leave co undriven at the ALU; never sample it.
                    if (arith) begin
                        carry_reg <= bus.alu_co;
                    end
                    if (idx_reg == LAST_IDX) begin
                        idx_reg <= '0;
                        // Result becomes visible together with the DONE state.
                        res_reg <= captured;
                        co_reg  <= arith ? bus.alu_co : 1'b0;
                        z_reg   <= (captured == '0);
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp_alu_seq.sv
// Bench for mp_alu_seq: byte-wide ALU model beside the DUT, directed corner
// cases followed by random operations checked against a full-width model.
module tb_mp_alu_seq;
    import mp_alu_seq_pkg::*;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_res = '0;

    always #5 clk = ~clk;

    mp_alu_seq_if #(.NBYTES(NBYTES)) bus();

    mp_alu_seq #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Byte ALU living in the parent; co is junk for logical ops.
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'h000;
        case (bus.alu_op)
            3'd0: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd1: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_ci};
            3'd2: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'h00, bus.alu_ci};
            3'd3: alu_t = {1'b0, bus.alu_a & bus.alu_b};
            3'd4: alu_t = {1'b0, bus.alu_a | bus.alu_b};
            3'd5: alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
            3'd6: alu_t = {1'b0, ~bus.alu_a};
            default: alu_t = 9'h000;
        endcase
        bus.alu_result = alu_t[7:0];
        bus.alu_co     = (bus.alu_op <= 3'd2) ? alu_t[8] : bus.alu_a[0];
    end

    // Full-width reference: {carry/borrow, result}.
    function automatic logic [W:0] ref_op(input logic [2:0] op, input logic ci,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            3'd2: return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
            3'd3: return {1'b0, a & b};
            3'd4: return {1'b0, a | b};
            3'd5: return {1'b0, a ^ b};
            3'd6: return {1'b0, ~a};
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Counts rising edges until done is seen; res_out must hold meanwhile.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.done !== 1'b1) check("res_hold", bus.res_out, last_res);
        end
    endtask

    task automatic check_result(input string tag, input logic [W:0] e);
        check({tag, "_res"}, bus.res_out, e[W-1:0]);
        check({tag, "_co"},  bus.co_out, e[W]);
        check({tag, "_z"},   bus.z_out, e[W-1:0] == '0);
        check({tag, "_idle_alu"}, {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_ci}, {3'd7, 17'h0});
        last_res = e[W-1:0];
    endtask

    task automatic run_op(input logic [2:0] op, input logic ci,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] e;
        int n;
        e = ref_op(op, ci, a, b);
        if (op > 3'd2) e[W] = 1'b0;
        @(negedge clk);
        bus.op_in = op; bus.ci_in = ci; bus.a_in = a; bus.b_in = b; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_run", bus.busy, 1);
        wait_done(n);
        check("latency", n, NBYTES);
        check_result("op", e);
        $display("txn op=%0d ci=%0b a=%h b=%h -> res=%h co=%0b z=%0b", op, ci, a, b,
                 bus.res_out, bus.co_out, bus.z_out);
        @(posedge clk); #1;
        check("done_pulse", bus.done, 0);
        check("busy_idle", bus.busy, 0);
    endtask

    initial begin
        int n;
        int seen;
        logic [W-1:0] a2, b2;
        bus.start = 1'b0; bus.op_in = 3'd0; bus.ci_in = 1'b0; bus.a_in = '0; bus.b_in = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_res", bus.res_out, 0);
        check("rst_co", bus.co_out, 0);
        check("rst_z", bus.z_out, 1);
        check("rst_alu_op", bus.alu_op, 7);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op(ALU_ADD, 1'b0, 32'h0000_00FF, 32'h0000_0001);
        run_op(ALU_ADD, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(ALU_SBB, 1'b0, 32'h0000_0000, 32'h0000_0001);
        run_op(ALU_SBB, 1'b0, 32'h1234_5678, 32'h0234_5678);
        run_op(ALU_ADC, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000);
        run_op(ALU_NOT, 1'b0, 32'h0F0F_00FF, 32'h1234_5678);
        run_op(ALU_XOR, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        run_op(ALU_ADD, 1'b1, 32'h0000_0001, 32'h0000_0001);  // ci ignored for ADD
        run_op(ALU_ZERO, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);

        // start held high; operands change while busy.
        a2 = 32'h1111_2222; b2 = 32'h0F0F_0F0F;
        @(negedge clk);
        bus.op_in = ALU_ADD; bus.ci_in = 1'b0; bus.a_in = 32'h8000_00F0; bus.b_in = 32'h8000_0010;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a_in = a2; bus.b_in = b2;
        wait_done(n);
        check("held_latency", n, NBYTES);
        check_result("held1", ref_op(ALU_ADD, 1'b0, 32'h8000_00F0, 32'h8000_0010));
        @(posedge clk); #1;
        check("held_idle_gap", bus.busy, 0);
        @(posedge clk); #1;
        check("held_recapture", bus.busy, 1);
        bus.start = 1'b0;
        wait_done(n);
        check("held2_latency", n, NBYTES);
        check_result("held2", ref_op(ALU_ADD, 1'b0, a2, b2));
        $display("txn held-start second op res=%h co=%0b", bus.res_out, bus.co_out);
        @(posedge clk); #1;

        // Reset during the second RUN byte.
        run_op(ALU_ADD, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002);
        @(negedge clk);
        bus.op_in = ALU_ADD; bus.a_in = 32'h0101_0101; bus.b_in = 32'h0202_0202; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_res", bus.res_out, 0);
        check("arst_co", bus.co_out, 0);
        check("arst_z", bus.z_out, 1);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        check("arst_no_done", seen, 0);
        $display("txn reset mid-run");
        run_op(ALU_ADD, 1'b0, 32'h0101_0101, 32'h0202_0202);

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (i % 8 == 3) b = ~a;
            if (i % 8 == 5) a = 32'hFFFF_FFFF;
            run_op(op, 1'($urandom_range(0, 1)), a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
